// File: rtl/bus_pkg.sv
// Shared bus definitions: address/data defaults, slave ID width and the
// memory-controller state encoding.
package bus_pkg;
  localparam int ID_WIDTH       = 3;
  localparam int BUS_ADDR_WIDTH = 15;
  localparam int BUS_DATA_WIDTH = 8;

  typedef logic [1:0] smc_state_t;

  localparam smc_state_t SMC_IDLE   = 2'd0;
  localparam smc_state_t SMC_WAIT   = 2'd1;
  localparam smc_state_t SMC_ACCESS = 2'd2;
  localparam smc_state_t SMC_DONE   = 2'd3;
endpackage

// File: rtl/slave_mem_array.sv
// Single-port byte-wide RAM with a registered read and no reset.
module slave_mem_array #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/slave_mem_ctrl.sv
// Memory-side controller behind a bus slave: latches one request, waits
// WAIT_CYCLES, performs the RAM access and pulses module_dv for one cycle.
module slave_mem_ctrl
  import bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic                     rd_req,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     module_dv,
  output logic                     busy,
  output logic                     addr_err,
  output logic                     ovf_err,
  output smc_state_t               state_dbg
);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  smc_state_t state_q, state_d;
  logic [3:0]               wait_cnt_q, wait_cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     is_wr_q, is_wr_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     dv_q, dv_d;
  logic                     aerr_q, aerr_d;
  logic                     ovf_q, ovf_d;

  logic                      req;
  logic                      out_of_range;
  logic                      ram_we;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]     ram_rdata;
  logic [ID_WIDTH-1:0]       unused_id_bits;

  assign req = wr_en | rd_req;

  // The slave has already matched the ID, so those bits play no part here.
  assign unused_id_bits = addr_q[ADDRESS_WIDTH-1 -: ID_WIDTH];

  generate
    if (MEM_ADDR_WIDTH < ADDRESS_WIDTH - ID_WIDTH) begin : g_range_chk
      assign out_of_range = |addr_q[ADDRESS_WIDTH-ID_WIDTH-1:MEM_ADDR_WIDTH];
    end else begin : g_no_range_chk
      assign out_of_range = 1'b0;
    end
  endgenerate

  // RAM read is issued the cycle before ACCESS; in IDLE that is the live
  // address, which matters when there are no wait states.
  assign ram_addr = (state_q == SMC_IDLE) ? addr[MEM_ADDR_WIDTH-1:0]
                                          : addr_q[MEM_ADDR_WIDTH-1:0];

  slave_mem_array #(
    .AW(MEM_ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= SMC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SMC_IDLE:   if (req) state_d = (WAIT_CYCLES > 0) ? SMC_WAIT : SMC_ACCESS;
      SMC_WAIT:   if (wait_cnt_q == WAIT_LAST) state_d = SMC_ACCESS;
      SMC_ACCESS: state_d = SMC_DONE;
      SMC_DONE:   state_d = SMC_IDLE;
      default:    state_d = SMC_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    rd_data_d  = rd_data_q;
    dv_d       = dv_q;
    aerr_d     = aerr_q;
    ovf_d      = ovf_q;
    ram_we     = 1'b0;
    // A request outside IDLE, or a read colliding with a write, is dropped.
    if (state_q != SMC_IDLE && req) ovf_d = 1'b1;
    case (state_q)
      SMC_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wr_data;
          is_wr_d = wr_en;
          if (wr_en && rd_req) ovf_d = 1'b1;
        end
      end
      SMC_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) wait_cnt_d = 4'd0;
        else                         wait_cnt_d = wait_cnt_q + 4'd1;
      end
      SMC_ACCESS: begin
        dv_d   = 1'b1;
        aerr_d = out_of_range;
        if (is_wr_q) ram_we = ~out_of_range;
        else         rd_data_d = out_of_range ? '1 : ram_rdata;
      end
      SMC_DONE: begin
        dv_d   = 1'b0;
        aerr_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rd_data_q  <= '0;
      dv_q       <= 1'b0;
      aerr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      rd_data_q  <= rd_data_d;
      dv_q       <= dv_d;
      aerr_q     <= aerr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign module_dv = dv_q;
  assign addr_err  = aerr_q;
  assign ovf_err   = ovf_q;
  assign busy      = (state_q != SMC_IDLE);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_slave_mem_ctrl.sv
// Directed bench for slave_mem_ctrl: three instances (default, no wait
// states, 10-bit RAM index) share one stimulus stream.
module tb_slave_mem_ctrl;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic        rd_req;
  logic [14:0] addr;
  logic [7:0]  wr_data;

  logic [7:0]  rd_data_w [3];
  logic        dv_w      [3];
  logic        busy_w    [3];
  logic        aerr_w    [3];
  logic        ovf_w     [3];
  smc_state_t  state_w   [3];

  int n_checks = 0;
  int n_fail   = 0;

  int         lat_obs  [3];
  int         dv_cnt   [3];
  logic [7:0] rd_obs   [3];
  logic       aerr_obs [3];
  logic       busy_obs0;

  always #5 clk = ~clk;

  slave_mem_ctrl #(.MEM_ADDR_WIDTH(12), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .rd_req(rd_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_w[0]), .module_dv(dv_w[0]),
    .busy(busy_w[0]), .addr_err(aerr_w[0]), .ovf_err(ovf_w[0]),
    .state_dbg(state_w[0]));

  slave_mem_ctrl #(.MEM_ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .rd_req(rd_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_w[1]), .module_dv(dv_w[1]),
    .busy(busy_w[1]), .addr_err(aerr_w[1]), .ovf_err(ovf_w[1]),
    .state_dbg(state_w[1]));

  slave_mem_ctrl #(.MEM_ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .rd_req(rd_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_w[2]), .module_dv(dv_w[2]),
    .busy(busy_w[2]), .addr_err(aerr_w[2]), .ovf_err(ovf_w[2]),
    .state_dbg(state_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Issue one request, then watch 8 edges and record, per instance, the
  // first module_dv cycle with its rd_data/addr_err and the pulse length.
  task automatic run_req(input logic w, input logic r, input logic [14:0] a,
                         input logic [7:0] d, input bit late_rd);
    @(negedge clk);
    wr_en = w; rd_req = r; addr = a; wr_data = d;
    for (int i = 0; i < 3; i++) begin
      lat_obs[i] = 0; dv_cnt[i] = 0; rd_obs[i] = 8'h00; aerr_obs[i] = 1'b0;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_req = late_rd;
    busy_obs0 = busy_w[0];
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      rd_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (dv_w[i]) dv_cnt[i]++;
        if (dv_w[i] && lat_obs[i] == 0) begin
          lat_obs[i]  = c;
          rd_obs[i]   = rd_data_w[i];
          aerr_obs[i] = aerr_w[i];
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; rd_req = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_data", rd_data_w[0], 8'h00);
    check("rst_dv",      dv_w[0],      1'b0);
    check("rst_busy",    busy_w[0],    1'b0);
    check("rst_aerr",    aerr_w[0],    1'b0);
    check("rst_ovf",     ovf_w[0],     1'b0);
    check("rst_state",   state_w[0],   SMC_IDLE);
    rstn = 1'b1;

    // Write then read at default timing
    run_req(1'b1, 1'b0, 15'h0005, 8'hA5, 1'b0);
    check("wr05_busy",    busy_obs0,   1'b1);
    check("wr05_lat0",    lat_obs[0],  3);
    check("wr05_dvlen0",  dv_cnt[0],   1);
    check("wr05_lat1",    lat_obs[1],  1);
    check("wr05_aerr0",   aerr_obs[0], 1'b0);
    run_req(1'b0, 1'b1, 15'h0005, 8'h00, 1'b0);
    check("rd05_lat0",    lat_obs[0],  3);
    check("rd05_data0",   rd_obs[0],   8'hA5);
    check("rd05_data1",   rd_obs[1],   8'hA5);
    check("rd05_data2",   rd_obs[2],   8'hA5);

    // Top of a 12-bit RAM; out of range for the 10-bit instance
    run_req(1'b1, 1'b0, 15'h0FFF, 8'h3C, 1'b0);
    check("wrfff_lat1",   lat_obs[1],  1);
    check("wrfff_aerr2",  aerr_obs[2], 1'b1);
    run_req(1'b0, 1'b1, 15'h0FFF, 8'h00, 1'b0);
    check("rdfff_lat1",   lat_obs[1],  1);
    check("rdfff_dvlen1", dv_cnt[1],   1);
    check("rdfff_data1",  rd_obs[1],   8'h3C);
    check("rdfff_data0",  rd_obs[0],   8'h3C);
    check("rdfff_data2",  rd_obs[2],   8'hFF);
    check("rdfff_aerr2",  aerr_obs[2], 1'b1);
    check("no_ovf_yet",   ovf_w[0],    1'b0);

    // Out-of-range write must not alias onto RAM[0] of the 10-bit instance
    run_req(1'b1, 1'b0, 15'h0000, 8'h5A, 1'b0);
    run_req(1'b1, 1'b0, 15'h0400, 8'h99, 1'b0);
    check("wr400_aerr2",  aerr_obs[2], 1'b1);
    check("wr400_aerr0",  aerr_obs[0], 1'b0);
    check("wr400_lat2",   lat_obs[2],  3);
    run_req(1'b0, 1'b1, 15'h0400, 8'h00, 1'b0);
    check("rd400_data2",  rd_obs[2],   8'hFF);
    check("rd400_aerr2",  aerr_obs[2], 1'b1);
    check("rd400_data0",  rd_obs[0],   8'h99);
    check("aerr_cleared", aerr_w[2],   1'b0);
    run_req(1'b0, 1'b1, 15'h0000, 8'h00, 1'b0);
    check("rd000_data2",  rd_obs[2],   8'h5A);

    // Read request while busy is dropped
    run_req(1'b1, 1'b0, 15'h0010, 8'h11, 1'b1);
    check("ovf_wr_lat0",  lat_obs[0],  3);
    check("ovf_rd_hold0", rd_obs[0],   8'h5A);
    check("ovf_set0",     ovf_w[0],    1'b1);
    check("ovf_set1",     ovf_w[1],    1'b1);
    run_req(1'b0, 1'b1, 15'h0010, 8'h00, 1'b0);
    check("rd010_data0",  rd_obs[0],   8'h11);
    check("ovf_sticky0",  ovf_w[0],    1'b1);

    // Simultaneous write and read: write wins
    do_reset();
    #1;
    check("ovf_rst_clr",  ovf_w[0],    1'b0);
    run_req(1'b1, 1'b1, 15'h0030, 8'h42, 1'b0);
    check("both_lat0",    lat_obs[0],  3);
    check("both_rd0",     rd_obs[0],   8'h00);
    check("both_ovf0",    ovf_w[0],    1'b1);
    run_req(1'b0, 1'b1, 15'h0030, 8'h00, 1'b0);
    check("rd030_data0",  rd_obs[0],   8'h42);

    // Reset during WAIT of a write aborts it
    run_req(1'b1, 1'b0, 15'h0020, 8'h00, 1'b0);
    @(negedge clk);
    wr_en = 1'b1; addr = 15'h0020; wr_data = 8'h77;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    check("mid_busy",     busy_w[0],   1'b1);
    check("mid_state",    state_w[0],  SMC_WAIT);
    rstn = 1'b0;
    #1;
    check("mid_rst_dv",   dv_w[0],     1'b0);
    check("mid_rst_busy", busy_w[0],   1'b0);
    check("mid_rst_rd",   rd_data_w[0], 8'h00);
    check("mid_rst_st",   state_w[0],  SMC_IDLE);
    @(negedge clk);
    rstn = 1'b1;
    dv_cnt[0] = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (dv_w[0]) dv_cnt[0]++;
    end
    check("mid_no_dv",    dv_cnt[0],   0);
    run_req(1'b0, 1'b1, 15'h0020, 8'h00, 1'b0);
    check("rd020_lat0",   lat_obs[0],  3);
    check("rd020_data0",  rd_obs[0],   8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
